sync_fifo: RTL and testbench

Single-clock synchronous FIFO that accepts words from a producer on `wr_en`/`data_in` and returns them in order on `rd_en`/`data_out`, with `empty`/`full` status. It is the device that responds to the driver-side `wr_en`/`rd_en`/`data_in` signalling of the FIFO verification interface. All signal names match that interface so the block binds to it directly. It adds occupancy and error-pulse outputs for scoreboard checking.

---
 rtl/sync_fifo.sv | 63 ++++++
 tb/tb_sync_fifo.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data, occupancy count and
// one-cycle overflow/underflow pulses for scoreboard checking.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] data_in,
  input  logic             rd_en,
  output logic [WIDTH-1:0] data_out,
  output logic             empty,
  output logic             full,
  output logic [AW:0]      count,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             wr_accept;
  logic             rd_accept;

  // Pointers carry an extra wrap bit so equal low bits distinguish full from empty.
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count     = wr_ptr - rd_ptr;
  assign wr_accept = wr_en && !full;
  assign rd_accept = rd_en && !empty;

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_ptr[AW-1:0]] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      data_out  <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= wr_en && full;
      underflow <= rd_en && empty;
      if (wr_accept) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (rd_accept) begin
        data_out <= mem[rd_ptr[AW-1:0]];
        rd_ptr   <= rd_ptr + PTR_ONE;
      end
    end
  end

endmodule

// File: tb/tb_sync_fifo.sv
// Randomized and directed bench for sync_fifo, checked against a queue-based
// reference model of FIFO occupancy and ordering.
module tb_sync_fifo;

  localparam int WIDTH = 16;
  localparam int DEPTH = 16;
  localparam int AW    = $clog2(DEPTH);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             wr_en;
  logic [WIDTH-1:0] data_in;
  logic             rd_en;
  logic [WIDTH-1:0] data_out;
  logic             empty;
  logic             full;
  logic [AW:0]      count;
  logic             overflow;
  logic             underflow;

  int compareCount  = 0;
  int mismatchCount = 0;

  logic [WIDTH-1:0] model[$];
  logic [WIDTH-1:0] expData;
  logic             expOvf;
  logic             expUnd;

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .data_in   (data_in),
    .rd_en     (rd_en),
    .data_out  (data_out),
    .empty     (empty),
    .full      (full),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic checkState(input string tag);
    checkOutput({tag, ".data_out"},  32'(data_out),  32'(expData));
    checkOutput({tag, ".count"},     32'(count),     32'(model.size()));
    checkOutput({tag, ".empty"},     32'(empty),     32'(model.size() == 0));
    checkOutput({tag, ".full"},      32'(full),      32'(model.size() == DEPTH));
    checkOutput({tag, ".overflow"},  32'(overflow),  32'(expOvf));
    checkOutput({tag, ".underflow"}, 32'(underflow), 32'(expUnd));
  endtask

  // One clock of traffic; the model decides acceptance from the pre-edge occupancy.
  task automatic applyStimulus(input string tag, input logic wr, input logic rd,
                               input logic [WIDTH-1:0] din);
    int pre;
    wr_en   = wr;
    rd_en   = rd;
    data_in = din;
    @(posedge clk);
    #1;
    pre    = model.size();
    expOvf = wr && (pre == DEPTH);
    expUnd = rd && (pre == 0);
    if (rd && pre > 0) expData = model.pop_front();
    if (wr && pre < DEPTH) model.push_back(din);
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    checkState(tag);
  endtask

  initial begin
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    data_in = '0;
    expData = '0;
    expOvf  = 1'b0;
    expUnd  = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    checkState("reset");
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) applyStimulus("idle", 1'b0, 1'b0, 16'hFFFF);

    for (int i = 1; i <= DEPTH; i++) applyStimulus("fill", 1'b1, 1'b0, WIDTH'(i));
    checkOutput("fill.full_after_16", 32'(full), 32'd1);
    checkOutput("fill.count_after_16", 32'(count), 32'd16);

    applyStimulus("overflow", 1'b1, 1'b0, 16'hBEEF);
    applyStimulus("overflow_clear", 1'b0, 1'b0, 16'h0000);

    for (int i = 1; i <= DEPTH; i++) begin
      applyStimulus("drain", 1'b0, 1'b1, 16'h0000);
      checkOutput("drain.order", 32'(data_out), 32'(i));
    end
    checkOutput("drain.empty", 32'(empty), 32'd1);

    applyStimulus("underflow", 1'b0, 1'b1, 16'h0000);
    applyStimulus("underflow_clear", 1'b0, 1'b0, 16'h0000);

    applyStimulus("wr_rd_empty", 1'b1, 1'b1, 16'h00A5);
    checkOutput("wr_rd_empty.count", 32'(count), 32'd1);
    applyStimulus("wr_rd_empty_read", 1'b0, 1'b1, 16'h0000);
    checkOutput("wr_rd_empty.data", 32'(data_out), 32'h00A5);

    for (int i = 0; i < DEPTH; i++) applyStimulus("refill", 1'b1, 1'b0, 16'h0200 + WIDTH'(i));
    applyStimulus("wr_rd_full", 1'b1, 1'b1, 16'hDEAD);
    checkOutput("wr_rd_full.count", 32'(count), 32'd15);
    checkOutput("wr_rd_full.oldest", 32'(data_out), 32'h0200);
    while (model.size() > 0) applyStimulus("drain2", 1'b0, 1'b1, 16'h0000);

    for (int i = 0; i < 4; i++) applyStimulus("prime", 1'b1, 1'b0, 16'h0100 + WIDTH'(i));
    for (int i = 4; i < 44; i++) begin
      applyStimulus("stream", 1'b1, 1'b1, 16'h0100 + WIDTH'(i));
      checkOutput("stream.order", 32'(data_out), 32'(16'h0100 + WIDTH'(i - 4)));
    end

    for (int i = 0; i < 400; i++) begin
      applyStimulus("random", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    WIDTH'($urandom));
    end

    while (model.size() < 9) applyStimulus("to_nine", 1'b1, 1'b0, WIDTH'($urandom));
    while (model.size() > 9) applyStimulus("to_nine", 1'b0, 1'b1, 16'h0000);
    if (data_out == '0) begin
      applyStimulus("nonzero_out", 1'b1, 1'b1, 16'h7777);
    end
    rst_n = 1'b0;
    #2;
    model.delete();
    expData = '0;
    expOvf  = 1'b0;
    expUnd  = 1'b0;
    checkState("mid_reset");
    #1;
    rst_n = 1'b1;
    applyStimulus("post_reset_wr", 1'b1, 1'b0, 16'h1234);
    applyStimulus("post_reset_rd", 1'b0, 1'b1, 16'h0000);
    checkOutput("post_reset.data", 32'(data_out), 32'h1234);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
